// File: rtl/mda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mda_pkg
// Description : Shared constants, attribute classes and cell record for the
//               MDA pixel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package mda_pkg;

    localparam int CELL_W = 9;

    localparam int ATTR_FG_LSB  = 0;
    localparam int ATTR_FG_MSB  = 2;
    localparam int ATTR_INT     = 3;
    localparam int ATTR_BG_LSB  = 4;
    localparam int ATTR_BG_MSB  = 6;
    localparam int ATTR_BLINK   = 7;

    // Box-drawing range whose glyphs extend into the 9th column
    localparam logic [7:0] BOX_LO = 8'hC0;
    localparam logic [7:0] BOX_HI = 8'hDF;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        NONDISP = 2'd1,
        REVERSE = 2'd2,
        ULINE   = 2'd3
    } attr_class_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] code;
        logic [7:0] attr;
        logic [3:0] row;
        logic       cursor;
    } cell_info_t;

    function automatic logic is_box_code(input logic [7:0] c);
        return (c >= BOX_LO) && (c <= BOX_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mda_attr_decode.sv
`default_nettype none
// ============================================================================
// Module      : mda_attr_decode
// Description : Classifies an MDA attribute byte into normal, nondisplay,
//               reverse or underline video.
// Revision    : 1.0 - initial release
// ============================================================================
module mda_attr_decode
    import mda_pkg::*;
(
    input  logic [7:0] attr,
    output logic [1:0] attr_class
);

    logic [2:0]  w_fg;
    logic [2:0]  w_bg;
    attr_class_e w_class;

    assign w_fg = attr[ATTR_FG_MSB:ATTR_FG_LSB];
    assign w_bg = attr[ATTR_BG_MSB:ATTR_BG_LSB];

    // Intensity and blink bits do not take part in the classification
    always_comb begin
        w_class = NORMAL;
        if (w_fg == 3'b000 && w_bg == 3'b000) begin
            w_class = NONDISP;
        end else if (w_fg == 3'b000 && w_bg == 3'b111) begin
            w_class = REVERSE;
        end else if (w_fg == 3'b001 && w_bg == 3'b000) begin
            w_class = ULINE;
        end
    end

    assign attr_class = w_class;

endmodule
`default_nettype wire

// File: rtl/mda_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : mda_pixel_shifter
// Description : Aligns cell fields with the font ROM row, applies MDA
//               attribute/blink/cursor rules and serialises 9 dots per cell.
// Revision    : 1.0 - initial release
// ============================================================================
module mda_pixel_shifter
    import mda_pkg::*;
#(
    parameter int ROM_LAT   = 2,
    parameter int ULINE_ROW = 12,
    parameter int BLINK_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cell_start,
    input  logic [7:0] code,
    input  logic [7:0] attr,
    input  logic [3:0] row,
    input  logic       cursor,
    input  logic [3:0] cur_start,
    input  logic [3:0] cur_end,
    input  logic       blink_en,
    input  logic       vsync_pulse,
    input  logic [7:0] font_data,
    output logic       pix_valid,
    output logic       pix_video,
    output logic       pix_intense
);

    localparam logic [3:0] c_ULINE_ROW = 4'(ULINE_ROW);
    localparam logic [3:0] c_LAST_DOT  = 4'(CELL_W - 1);

    cell_info_t          w_in;
    cell_info_t          r_pipe [ROM_LAT];
    cell_info_t          w_cur;
    logic [4:0]          r_frame_cnt;
    logic [1:0]          w_class_raw;
    attr_class_e         w_class;
    logic                w_ninth;
    logic [CELL_W-1:0]   w_glyph;
    logic                w_uline_row;
    logic                w_blink_off;
    logic                w_cursor_on;
    logic [CELL_W-1:0]   w_word;
    logic                w_int;
    logic [CELL_W-1:0]   r_sh;
    logic [3:0]          r_cnt;
    logic                r_valid;
    logic                r_int;

    always_comb begin
        w_in        = '0;
        w_in.valid  = cell_start;
        w_in.code   = code;
        w_in.attr   = attr;
        w_in.row    = row;
        w_in.cursor = cursor;
    end

    // Cell fields ride alongside the ROM lookup so they meet font_data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_cur = r_pipe[ROM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (vsync_pulse) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    mda_attr_decode u_attr_decode (
        .attr       (w_cur.attr),
        .attr_class (w_class_raw)
    );

    assign w_class     = attr_class_e'(w_class_raw);
    assign w_ninth     = is_box_code(w_cur.code) & font_data[0];
    assign w_glyph     = {font_data, w_ninth};
    assign w_uline_row = (w_cur.row == c_ULINE_ROW);
    assign w_blink_off = blink_en & w_cur.attr[ATTR_BLINK] & r_frame_cnt[BLINK_BIT];
    assign w_cursor_on = w_cur.cursor
                       & (cur_start <= w_cur.row)
                       & (w_cur.row <= cur_end)
                       & ~r_frame_cnt[3];

    // Order matters: blank, then underline, then reverse, cursor last
    always_comb begin
        w_word = w_glyph;
        w_int  = w_cur.attr[ATTR_INT];
        if (w_class == NONDISP || w_blink_off) begin
            w_word = '0;
        end
        if (w_class == ULINE && w_uline_row && !w_blink_off) begin
            w_word = '1;
        end
        if (w_class == REVERSE) begin
            w_word = ~w_word;
            w_int  = w_cur.attr[ATTR_BLINK] & ~blink_en;
        end
        if (w_cursor_on) begin
            w_word = '1;
            w_int  = w_cur.attr[ATTR_INT];
        end
    end

    // A new load always wins over a cell still being shifted out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_int   <= 1'b0;
        end else if (w_cur.valid) begin
            r_sh    <= w_word;
            r_cnt   <= c_LAST_DOT;
            r_valid <= 1'b1;
            r_int   <= w_int;
        end else if (r_valid) begin
            if (r_cnt == 4'd0) begin
                r_sh    <= '0;
                r_valid <= 1'b0;
                r_int   <= 1'b0;
            end else begin
                r_sh  <= {r_sh[CELL_W-2:0], 1'b0};
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign pix_valid   = r_valid;
    assign pix_video   = r_valid & r_sh[CELL_W-1];
    assign pix_intense = r_valid & r_sh[CELL_W-1] & r_int;

endmodule
`default_nettype wire

// File: tb/tb_mda_pixel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mda_pixel_shifter
// Description : Directed self-checking bench for mda_pixel_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mda_pixel_shifter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cell_start;
    logic [7:0] code;
    logic [7:0] attr;
    logic [3:0] row;
    logic       cursor;
    logic [3:0] cur_start;
    logic [3:0] cur_end;
    logic       blink_en;
    logic       vsync_pulse;
    logic [7:0] font_data;
    logic       pix_valid;
    logic       pix_video;
    logic       pix_intense;

    int total = 0;
    int bad   = 0;

    mda_pixel_shifter #(.ROM_LAT(2), .ULINE_ROW(12), .BLINK_BIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cell_start  (cell_start),
        .code        (code),
        .attr        (attr),
        .row         (row),
        .cursor      (cursor),
        .cur_start   (cur_start),
        .cur_end     (cur_end),
        .blink_en    (blink_en),
        .vsync_pulse (vsync_pulse),
        .font_data   (font_data),
        .pix_valid   (pix_valid),
        .pix_video   (pix_video),
        .pix_intense (pix_intense)
    );

    always #5 clk = ~clk;

    task automatic start_cell(input logic [7:0] c, input logic [7:0] a, input logic [3:0] r,
                              input logic cur, input logic [7:0] f);
        @(posedge clk); #1;
        cell_start = 1'b1; code = c; attr = a; row = r; cursor = cur; font_data = f;
        @(posedge clk); #1;
        cell_start = 1'b0;
    endtask

    // Collects the 9 dot cycles starting at T+3, then the first cycle after
    task automatic run_cell(input logic [7:0] c, input logic [7:0] a, input logic [3:0] r,
                            input logic cur, input logic [7:0] f,
                            output logic [8:0] v, output logic [8:0] in,
                            output logic [8:0] vl, output logic tail);
        start_cell(c, a, r, cur, f);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 9; k++) begin
            v[8-k]  = pix_video;
            in[8-k] = pix_intense;
            vl[8-k] = pix_valid;
            @(posedge clk); #1;
        end
        tail = pix_valid | pix_video | pix_intense;
    endtask

    task automatic pulse_vsync(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; vsync_pulse = 1'b1;
            @(posedge clk); #1; vsync_pulse = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pix_valid); end
        total++; if (pix_video !== 1'b0) begin bad++; $display("FAIL reset_video got=%b exp=0", pix_video); end
        total++; if (pix_intense !== 1'b0) begin bad++; $display("FAIL reset_intense got=%b exp=0", pix_intense); end
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", pix_valid); end
    endtask

    task automatic test_basic();
        logic [8:0] v, in, vl; logic tail;
        run_cell(8'h41, 8'h07, 4'd5, 1'b0, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b000110000) begin bad++; $display("FAIL basic_video got=%b exp=%b", v, 9'b000110000); end
        total++; if (vl !== 9'h1FF) begin bad++; $display("FAIL basic_valid got=%b exp=%b", vl, 9'h1FF); end
        total++; if (in !== 9'h000) begin bad++; $display("FAIL basic_intense got=%b exp=%b", in, 9'h000); end
        total++; if (tail !== 1'b0) begin bad++; $display("FAIL basic_gap got=%b exp=0", tail); end
    endtask

    task automatic test_ninth();
        logic [8:0] v, in, vl; logic tail;
        run_cell(8'hC4, 8'h07, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'h1FF) begin bad++; $display("FAIL ninth_box got=%b exp=%b", v, 9'h1FF); end
        run_cell(8'h41, 8'h07, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'b111111110) begin bad++; $display("FAIL ninth_plain got=%b exp=%b", v, 9'b111111110); end
        run_cell(8'hE0, 8'h07, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'b111111110) begin bad++; $display("FAIL ninth_above got=%b exp=%b", v, 9'b111111110); end
        run_cell(8'hDF, 8'h07, 4'd5, 1'b0, 8'h01, v, in, vl, tail);
        total++; if (v !== 9'b000000011) begin bad++; $display("FAIL ninth_top got=%b exp=%b", v, 9'b000000011); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] v, vl; logic tail;
        v = '0; vl = '0; tail = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 22; c++) begin
            cell_start = (c == 0) || (c == 9);
            code       = (c < 9) ? 8'hC4 : 8'h41;
            attr       = 8'h07; row = 4'd3; cursor = 1'b0; font_data = 8'hFF;
            if (c >= 3 && c < 21) begin
                v[20-c]  = pix_video;
                vl[20-c] = pix_valid;
            end
            if (c == 21) tail = pix_valid;
            @(posedge clk); #1;
        end
        cell_start = 1'b0;
        total++; if (v !== 18'b111111111_111111110) begin bad++; $display("FAIL b2b_video got=%b exp=%b", v, 18'b111111111_111111110); end
        total++; if (vl !== 18'h3FFFF) begin bad++; $display("FAIL b2b_valid got=%b exp=%b", vl, 18'h3FFFF); end
        total++; if (tail !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", tail); end
    endtask

    task automatic test_reverse_nondisp();
        logic [8:0] v, in, vl; logic tail;
        run_cell(8'h41, 8'h70, 4'd5, 1'b0, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b111001111) begin bad++; $display("FAIL reverse_video got=%b exp=%b", v, 9'b111001111); end
        total++; if (in !== 9'h000) begin bad++; $display("FAIL reverse_intense got=%b exp=%b", in, 9'h000); end
        run_cell(8'h41, 8'h00, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'h000) begin bad++; $display("FAIL nondisp_video got=%b exp=%b", v, 9'h000); end
        total++; if (vl !== 9'h1FF) begin bad++; $display("FAIL nondisp_valid got=%b exp=%b", vl, 9'h1FF); end
        run_cell(8'h41, 8'h08, 4'd12, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'h000) begin bad++; $display("FAIL nondisp_int got=%b exp=%b", v, 9'h000); end
    endtask

    task automatic test_underline();
        logic [8:0] v, in, vl; logic tail;
        run_cell(8'h41, 8'h01, 4'd12, 1'b0, 8'h00, v, in, vl, tail);
        total++; if (v !== 9'h1FF) begin bad++; $display("FAIL uline_row12 got=%b exp=%b", v, 9'h1FF); end
        total++; if (in !== 9'h000) begin bad++; $display("FAIL uline_dim got=%b exp=%b", in, 9'h000); end
        run_cell(8'h41, 8'h01, 4'd11, 1'b0, 8'h00, v, in, vl, tail);
        total++; if (v !== 9'h000) begin bad++; $display("FAIL uline_row11 got=%b exp=%b", v, 9'h000); end
        run_cell(8'h41, 8'h09, 4'd12, 1'b0, 8'h00, v, in, vl, tail);
        total++; if (in !== 9'h1FF) begin bad++; $display("FAIL uline_intense got=%b exp=%b", in, 9'h1FF); end
        run_cell(8'h41, 8'h11, 4'd12, 1'b0, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b000110000) begin bad++; $display("FAIL uline_bg_nonzero got=%b exp=%b", v, 9'b000110000); end
    endtask

    task automatic test_blink();
        logic [8:0] v, in, vl; logic tail;
        blink_en = 1'b1;
        pulse_vsync(16);
        run_cell(8'h41, 8'h87, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'h000) begin bad++; $display("FAIL blink_off got=%b exp=%b", v, 9'h000); end
        run_cell(8'h41, 8'h07, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'b111111110) begin bad++; $display("FAIL blink_noattr got=%b exp=%b", v, 9'b111111110); end
        pulse_vsync(16);
        run_cell(8'h41, 8'h87, 4'd5, 1'b0, 8'hFF, v, in, vl, tail);
        total++; if (v !== 9'b111111110) begin bad++; $display("FAIL blink_on got=%b exp=%b", v, 9'b111111110); end
        total++; if (in !== 9'h000) begin bad++; $display("FAIL blink_on_int got=%b exp=%b", in, 9'h000); end
        blink_en = 1'b0;
        run_cell(8'h41, 8'hF0, 4'd5, 1'b0, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b111001111) begin bad++; $display("FAIL bright_rev_video got=%b exp=%b", v, 9'b111001111); end
        total++; if (in !== 9'b111001111) begin bad++; $display("FAIL bright_rev_int got=%b exp=%b", in, 9'b111001111); end
    endtask

    task automatic test_cursor();
        logic [8:0] v, in, vl; logic tail;
        cur_start = 4'd11; cur_end = 4'd12;
        run_cell(8'h41, 8'h07, 4'd11, 1'b1, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'h1FF) begin bad++; $display("FAIL cursor_row11 got=%b exp=%b", v, 9'h1FF); end
        total++; if (in !== 9'h000) begin bad++; $display("FAIL cursor_dim got=%b exp=%b", in, 9'h000); end
        run_cell(8'h41, 8'h00, 4'd12, 1'b1, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'h1FF) begin bad++; $display("FAIL cursor_nondisp got=%b exp=%b", v, 9'h1FF); end
        run_cell(8'h41, 8'h0F, 4'd12, 1'b1, 8'h18, v, in, vl, tail);
        total++; if (in !== 9'h1FF) begin bad++; $display("FAIL cursor_intense got=%b exp=%b", in, 9'h1FF); end
        run_cell(8'h41, 8'h07, 4'd10, 1'b1, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b000110000) begin bad++; $display("FAIL cursor_row10 got=%b exp=%b", v, 9'b000110000); end
        cur_start = 4'd12; cur_end = 4'd11;
        run_cell(8'h41, 8'h07, 4'd12, 1'b1, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b000110000) begin bad++; $display("FAIL cursor_inverted got=%b exp=%b", v, 9'b000110000); end
        cur_start = 4'd11; cur_end = 4'd12;
        pulse_vsync(8);
        run_cell(8'h41, 8'h07, 4'd11, 1'b1, 8'h18, v, in, vl, tail);
        total++; if (v !== 9'b000110000) begin bad++; $display("FAIL cursor_phase got=%b exp=%b", v, 9'b000110000); end
    endtask

    task automatic test_reset_midcell();
        logic any;
        start_cell(8'h41, 8'h07, 4'd3, 1'b0, 8'hFF);
        repeat (6) @(posedge clk);
        #1;
        total++; if (pix_valid !== 1'b1 || pix_video !== 1'b1) begin
            bad++; $display("FAIL midcell_pre got=%b%b exp=11", pix_valid, pix_video);
        end
        rst_n = 1'b0;
        #1;
        total++; if ({pix_valid, pix_video, pix_intense} !== 3'b000) begin
            bad++; $display("FAIL midcell_async got=%b exp=000", {pix_valid, pix_video, pix_intense});
        end
        @(posedge clk); #1; cell_start = 1'b1;
        @(posedge clk); #1; cell_start = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            any = any | pix_valid | pix_video;
        end
        total++; if (any !== 1'b0) begin bad++; $display("FAIL midcell_after got=%b exp=0", any); end
    endtask

    initial begin
        rst_n = 1'b0; cell_start = 1'b0; code = '0; attr = '0; row = '0; cursor = 1'b0;
        cur_start = 4'd11; cur_end = 4'd12; blink_en = 1'b0; vsync_pulse = 1'b0; font_data = '0;
        test_reset();
        test_basic();
        test_ninth();
        test_back_to_back();
        test_reverse_nondisp();
        test_underline();
        test_blink();
        test_cursor();
        test_reset_midcell();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mda_pixel_shifter.md
Name: mda_pixel_shifter

Overview:
Downstream neighbour of the character-ROM stage in the MDA text pipeline. It takes the registered font row returned for each character cell, applies MDA attribute rules, and serialises the cell as 9 dots, one per clk. It also handles the 9th-dot rule, underline, reverse video, blanking, character blink and cursor.

Parameters:
ROM_LAT, 2, clk cycles from code/row presented to the character ROM until font_data is valid
ULINE_ROW, 12, glyph row on which underline is drawn
BLINK_BIT, 4, frame_cnt bit used as the character-blink phase (the cursor always uses bit 3)

Ports:
clk  in  1  dot clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cell_start  in  1  one-cycle pulse; code/attr/row/cursor are presented to the ROM and this block in the same cycle
code  in  8  character code of the cell
attr  in  8  MDA attribute byte
row  in  4  glyph row (0..13)
cursor  in  1  cell is the cursor position
cur_start  in  4  first cursor row
cur_end  in  4  last cursor row
blink_en  in  1  1: attr[7] means blink; 0: attr[7] means bright background
vsync_pulse  in  1  one-cycle frame tick
font_data  in  8  font row from the character ROM; bit 7 is the leftmost dot
pix_valid  out  1  a dot of a cell is on the outputs
pix_video  out  1  dot lit
pix_intense  out  1  lit dot is high intensity

Behaviour:
- Reset (async, rst_n=0): pix_valid, pix_video and pix_intense all 0; delay pipe, shifter, dot counter and frame_cnt all cleared. A cell in flight is discarded. No dots appear after release until a new cell_start.
- Delay pipe: code, attr, row, cursor and a valid bit are delayed ROM_LAT cycles so they align with font_data.
- Load: at cycle T+ROM_LAT (cell_start at T), font_data and the delayed fields are captured. A 9-bit dot word is formed, and the dot counter is set to 8.
- Output timing: dot 0 (bit 7) is on the outputs at T+ROM_LAT+1; dots 1..8 follow on consecutive cycles. pix_valid is high for exactly those 9 cycles.
- Cell overlap: cell_start pulses are nominally 9 cycles apart. If a load coincides with an unfinished cell, the new cell wins, the old cell is truncated, and there is no bubble.
- Gaps: if more than 9 cycles pass between loads, outputs are 0 in the gap.
- 9th dot: equals font bit 0 when code is in 0xC0..0xDF; otherwise 0.
- Attribute decode (fg=attr[2:0], bg=attr[6:4]):
  - fg=000 and bg=000: nondisplay; glyph and underline forced to 0.
  - fg=000 and bg=111: reverse; all 9 dots inverted after underline is applied.
  - fg=001 and bg=000: underline; all 9 dots are 1 when row==ULINE_ROW.
  - Any other value: normal video.
- Intensity: normal cells give pix_intense = attr[3] & pix_video. Reverse cells give pix_intense = attr[7] & ~blink_en & pix_video.
- frame_cnt: 5 bits, increments on vsync_pulse, wraps 31->0.
- Character blink: when blink_en & attr[7] & frame_cnt[BLINK_BIT], glyph and underline are forced to 0 before reverse is applied.
- Cursor: active when cursor=1, cur_start<=row<=cur_end and frame_cnt[3]==0. It forces all 9 dots to 1 with pix_intense=attr[3], and overrides nondisplay, reverse and blink. If cur_start>cur_end, no cursor is drawn.
- Simultaneous vsync_pulse and load: the load uses the pre-increment frame_cnt.
- cell_start during reset: ignored.

Decomposition:
- Package mda_pkg holds:
  - CELL_W=9
  - ATTR_FG/ATTR_INT/ATTR_BG/ATTR_BLINK field positions
  - BOX_LO=8'hC0, BOX_HI=8'hDF
  - the attr_class enum {NORMAL, NONDISP, REVERSE, ULINE}
- One combinational sub-module, mda_attr_decode: attr byte -> attr_class. The top level holds the delay pipe, frame counter, dot-word build and shifter.

Test Plan:
1. cell_start with code 0x41, attr 0x07, row 5, font_data 0x18 -> from T+3: pix_video 0,0,0,1,1,0,0,0,0; pix_valid high 9 cycles; pix_intense 0.
2. font_data 0xFF with code 0xC4 -> 9th dot 1. Same font_data with code 0x41 -> 9th dot 0. Back-to-back cells 9 apart -> pix_valid continuous with no bubble.
3. attr 0x70, font_data 0x18 -> pix_video 1,1,1,0,0,1,1,1,1. attr 0x00 with font 0xFF -> all 9 dots 0.
4. attr 0x01, font_data 0x00: row 12 -> 9 dots of 1; row 11 -> 9 dots of 0. attr 0x09, row 12 -> pix_intense 1 on all dots.
5. attr 0x87, blink_en=1, font 0xFF: after 16 vsync_pulses -> dots 0; after 32 -> dots shown. With blink_en=0, attr 0xF0 -> reverse dots carry pix_intense 1.
6. cursor=1, cur_start=11, cur_end=12: rows 11 and 12 -> 9 dots of 1; row 10 -> glyph. rst_n pulsed low at dot 4 -> outputs 0 the same cycle and no remaining dots after release.
